// File: rtl/reg_file.sv
// Integer register file: two registered read ports with write-first bypass,
// one write port, and a per-register busy scoreboard that drives a combinational stall.
module reg_file #(
    parameter int DATA_W   = 32,
    parameter int NUM_REGS = 32,
    parameter int ADDR_W   = 5
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [ADDR_W-1:0] p0_addr,
    input  logic [ADDR_W-1:0] p1_addr,
    input  logic              re0,
    input  logic              re1,
    input  logic [ADDR_W-1:0] dst_addr,
    input  logic [DATA_W-1:0] dst,
    input  logic              we,
    input  logic              busy_set,
    input  logic [ADDR_W-1:0] busy_addr,
    output logic [DATA_W-1:0] p0,
    output logic [DATA_W-1:0] p1,
    output logic              stall
);

    logic [DATA_W-1:0]   r_mem [NUM_REGS];
    logic [NUM_REGS-1:0] r_busy;
    logic [DATA_W-1:0]   r_p0;
    logic [DATA_W-1:0]   r_p1;

    logic              w_hit0;
    logic              w_hit1;
    logic              w_stall0;
    logic              w_stall1;
    logic              w_stall;
    logic [DATA_W-1:0] w_rd0;
    logic [DATA_W-1:0] w_rd1;

    assign w_hit0 = we && (dst_addr == p0_addr);
    assign w_hit1 = we && (dst_addr == p1_addr);

    // A same-cycle writeback to the pending register releases the stall.
    assign w_stall0 = re0 && (p0_addr != '0) && r_busy[p0_addr] && !w_hit0;
    assign w_stall1 = re1 && (p1_addr != '0) && r_busy[p1_addr] && !w_hit1;
    assign w_stall  = w_stall0 || w_stall1;

    always_comb begin
        w_rd0 = r_mem[p0_addr];
        if (p0_addr == '0) begin
            w_rd0 = '0;
        end else if (w_hit0) begin
            w_rd0 = dst;
        end
    end

    always_comb begin
        w_rd1 = r_mem[p1_addr];
        if (p1_addr == '0) begin
            w_rd1 = '0;
        end else if (w_hit1) begin
            w_rd1 = dst;
        end
    end

    // Writes are never gated by stall so writeback data is never lost.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < NUM_REGS; i++) begin
                r_mem[i] <= '0;
            end
        end else if (we && (dst_addr != '0)) begin
            r_mem[dst_addr] <= dst;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_busy <= '0;
        end else begin
            if (we) begin
                r_busy[dst_addr] <= 1'b0;
            end
            // Later assignment wins: a new producer overrides the retiring one.
            if (busy_set && (busy_addr != '0) && !w_stall) begin
                r_busy[busy_addr] <= 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_p0 <= '0;
            r_p1 <= '0;
        end else if (!w_stall) begin
            if (re0) begin
                r_p0 <= w_rd0;
            end
            if (re1) begin
                r_p1 <= w_rd1;
            end
        end
    end

    assign p0    = r_p0;
    assign p1    = r_p1;
    assign stall = w_stall;

endmodule

// File: tb/tb_reg_file.sv
// Directed bench for reg_file: driver pushes hand-computed read data into
// per-port queues, a monitor pops and compares after each rising edge.
module tb_reg_file;
    localparam int DATA_W = 32;
    localparam int ADDR_W = 5;

    logic              clk;
    logic              rst_n;
    logic [ADDR_W-1:0] p0_addr;
    logic [ADDR_W-1:0] p1_addr;
    logic              re0;
    logic              re1;
    logic [ADDR_W-1:0] dst_addr;
    logic [DATA_W-1:0] dst;
    logic              we;
    logic              busy_set;
    logic [ADDR_W-1:0] busy_addr;
    logic [DATA_W-1:0] p0;
    logic [DATA_W-1:0] p1;
    logic              stall;

    reg_file #(.DATA_W(DATA_W), .NUM_REGS(32), .ADDR_W(ADDR_W)) dut (
        .clk(clk), .rst_n(rst_n),
        .p0_addr(p0_addr), .p1_addr(p1_addr), .re0(re0), .re1(re1),
        .dst_addr(dst_addr), .dst(dst), .we(we),
        .busy_set(busy_set), .busy_addr(busy_addr),
        .p0(p0), .p1(p1), .stall(stall)
    );

    // clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // scoreboard state
    logic [DATA_W-1:0] exp0_q[$];
    logic [DATA_W-1:0] exp1_q[$];
    logic [DATA_W-1:0] held0;
    logic [DATA_W-1:0] held1;
    logic              issue0;
    logic              issue1;
    logic              mon_en;
    int                n_checks;
    int                n_errors;

    task automatic check(input string name, input logic [DATA_W-1:0] act,
                         input logic [DATA_W-1:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
        end
    endtask

    // monitor: compares registered read data one step after each edge
    always @(posedge clk) begin
        logic i0, i1, en;
        logic [DATA_W-1:0] e;
        en = mon_en;
        i0 = issue0;
        i1 = issue1;
        #1;
        if (en) begin
            if (i0) begin
                if (exp0_q.size() == 0) begin
                    check("p0_queue_underflow", 32'd1, 32'd0);
                end else begin
                    e = exp0_q.pop_front();
                    check("p0_load", p0, e);
                    held0 = e;
                end
            end else begin
                check("p0_hold", p0, held0);
            end
            if (i1) begin
                if (exp1_q.size() == 0) begin
                    check("p1_queue_underflow", 32'd1, 32'd0);
                end else begin
                    e = exp1_q.pop_front();
                    check("p1_load", p1, e);
                    held1 = e;
                end
            end else begin
                check("p1_hold", p1, held1);
            end
        end
    end

    // driver: one cycle of inputs, expected stall checked combinationally
    task automatic cyc(input logic r0, input logic [ADDR_W-1:0] a0,
                       input logic r1, input logic [ADDR_W-1:0] a1,
                       input logic w, input logic [ADDR_W-1:0] da,
                       input logic [DATA_W-1:0] d,
                       input logic bs, input logic [ADDR_W-1:0] ba,
                       input logic exp_stall,
                       input logic [DATA_W-1:0] e0, input logic [DATA_W-1:0] e1);
        @(negedge clk);
        re0 = r0; p0_addr = a0; re1 = r1; p1_addr = a1;
        we = w; dst_addr = da; dst = d; busy_set = bs; busy_addr = ba;
        #1;
        check("stall", {31'd0, stall}, {31'd0, exp_stall});
        issue0 = r0 && !exp_stall;
        issue1 = r1 && !exp_stall;
        if (issue0) exp0_q.push_back(e0);
        if (issue1) exp1_q.push_back(e1);
    endtask

    task automatic idle();
        cyc(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    endtask

    initial begin
        n_checks = 0; n_errors = 0;
        mon_en = 0; issue0 = 0; issue1 = 0; held0 = '0; held1 = '0;
        rst_n = 0; re0 = 0; re1 = 0; p0_addr = 0; p1_addr = 0;
        we = 0; dst_addr = 0; dst = 0; busy_set = 0; busy_addr = 0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1;
        #1;
        check("reset_p0", p0, 32'h0);
        check("reset_p1", p1, 32'h0);
        check("reset_stall", {31'd0, stall}, 32'h0);
        mon_en = 1;

        // r0 stays zero
        cyc(0, 0, 0, 0, 1, 0, 32'hDEADBEEF, 0, 0, 0, 0, 0);
        cyc(1, 0, 1, 0, 0, 0, 0, 0, 0, 0, 32'h0, 32'h0);
        // basic write then read on port 1
        cyc(0, 0, 0, 0, 1, 5, 32'h12345678, 0, 0, 0, 0, 0);
        cyc(0, 0, 1, 5, 0, 0, 0, 0, 0, 0, 0, 32'h12345678);
        // bypass over an older r7 value
        cyc(0, 0, 0, 0, 1, 7, 32'h11111111, 0, 0, 0, 0, 0);
        cyc(1, 7, 0, 0, 1, 7, 32'hA5A5A5A5, 0, 0, 0, 32'hA5A5A5A5, 0);
        cyc(1, 7, 0, 0, 0, 0, 0, 0, 0, 0, 32'hA5A5A5A5, 0);
        // stall on r3 for three cycles, busy_set r10 ignored while stalled
        cyc(0, 0, 0, 0, 0, 0, 0, 1, 3, 0, 0, 0);
        cyc(1, 3, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0);
        cyc(1, 3, 0, 0, 0, 0, 0, 1, 10, 1, 0, 0);
        cyc(1, 3, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0);
        cyc(1, 3, 0, 0, 1, 3, 32'h55, 0, 0, 0, 32'h55, 0);
        cyc(1, 3, 1, 10, 0, 0, 0, 0, 0, 0, 32'h55, 32'h0);
        // set/clear collision on r9: written and still busy
        cyc(0, 0, 0, 0, 1, 9, 32'h99, 1, 9, 0, 0, 0);
        cyc(1, 9, 1, 5, 0, 0, 0, 0, 0, 1, 0, 0);
        cyc(1, 9, 1, 5, 1, 9, 32'h77, 0, 0, 0, 32'h77, 32'h12345678);
        cyc(1, 9, 0, 0, 0, 0, 0, 0, 0, 0, 32'h77, 0);
        // dual-port stall on r2 and r4
        cyc(0, 0, 0, 0, 0, 0, 0, 1, 2, 0, 0, 0);
        cyc(0, 0, 0, 0, 0, 0, 0, 1, 4, 0, 0, 0);
        cyc(1, 2, 1, 4, 0, 0, 0, 0, 0, 1, 0, 0);
        cyc(1, 2, 1, 4, 1, 2, 32'h22, 0, 0, 1, 0, 0);
        cyc(1, 2, 1, 4, 1, 4, 32'h44, 0, 0, 0, 32'h22, 32'h44);
        // producer reading its own register in the issue cycle does not stall
        cyc(1, 12, 0, 0, 0, 0, 0, 1, 12, 0, 32'h0, 0);
        cyc(1, 12, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0);
        cyc(1, 12, 0, 0, 1, 12, 32'hC, 0, 0, 0, 32'hC, 0);
        // asynchronous reset in the middle of a stall
        cyc(0, 0, 0, 0, 0, 0, 0, 1, 6, 0, 0, 0);
        cyc(1, 6, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0);
        mon_en = 0;
        #2;
        rst_n = 0;
        #1;
        check("midrun_reset_stall", {31'd0, stall}, 32'h0);
        check("midrun_reset_p0", p0, 32'h0);
        check("midrun_reset_p1", p1, 32'h0);
        held0 = '0; held1 = '0;
        @(negedge clk);
        re0 = 0; re1 = 0; busy_set = 0; we = 0;
        rst_n = 1;
        mon_en = 1;
        // busy marks and array contents are gone after reset
        cyc(1, 6, 1, 5, 0, 0, 0, 0, 0, 0, 32'h0, 32'h0);
        cyc(1, 7, 1, 0, 0, 0, 0, 0, 0, 0, 32'h0, 32'h0);
        idle();
        idle();
        check("queues_drained", exp0_q.size() + exp1_q.size(), 32'h0);
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule
